// File: rtl/video_src_switch.sv
// Video source switch: selects one of NUM_CH pixel streams for the SDRAM writer and sequences a sensor reset on every mode change.
// Optional macro VIDEO_SRC_FRAME_SYNC_EN makes SYNC wait for frame_start so the first write after a switch is frame-aligned.
//
// state       | meaning
// ------------+------------------------------------------------------------
// S_RUN       | selected stream forwarded to SDRAM, requests evaluated
// S_RST_PULSE | camera_rstn held low for RST_LEN cycles, writes blocked
// S_SYNC      | sensor released, waiting before writes resume
module video_src_switch #(
  parameter int NUM_CH  = 2,
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 23,
  parameter int RST_LEN = 4,
  parameter logic [NUM_CH*ADDR_W-1:0] MAX_ADDR_LIST = {23'd655360, 23'd53248}
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid,
  input  logic [$clog2(NUM_CH)-1:0]  req_ch,
  input  logic                       req_custom,
  input  logic                       frame_start,
  input  logic [NUM_CH-1:0]          src_en,
  input  logic [NUM_CH*DATA_W-1:0]   src_data,
  output logic [DATA_W-1:0]          sdram_wrdata,
  output logic                       sdram_wren,
  output logic [ADDR_W-1:0]          sdram_max_addr,
  output logic                       camera_rstn,
  output logic                       custom,
  output logic [$clog2(NUM_CH)-1:0]  active_ch,
  output logic                       busy,
  output logic                       req_err
);

  localparam int CH_W = $clog2(NUM_CH);
  localparam logic [7:0] CNT_LAST = 8'(RST_LEN - 1);

  typedef enum logic [1:0] {S_RUN, S_RST_PULSE, S_SYNC} state_t;

  state_t          state, state_nxt;
  logic [CH_W-1:0] active_ch_nxt;
  logic            custom_nxt;
  logic            camera_rstn_nxt;
  logic            req_err_nxt;
  logic            pend_valid, pend_valid_nxt;
  logic [CH_W-1:0] pend_ch, pend_ch_nxt;
  logic            pend_custom, pend_custom_nxt;
  logic [7:0]      cnt, cnt_nxt;

  logic            req_legal;
  logic            fresh;
  logic            eval_valid;
  logic [CH_W-1:0] eval_ch;
  logic            eval_custom;
  logic            sync_done;

  assign req_legal = 32'(req_ch) < NUM_CH;
  assign fresh     = req_valid && req_legal;

  // A fresh request in RUN wins over the pending one, which is dropped either way.
  assign eval_valid  = fresh || pend_valid;
  assign eval_ch     = fresh ? req_ch : pend_ch;
  assign eval_custom = fresh ? req_custom : pend_custom;

`ifdef VIDEO_SRC_FRAME_SYNC_EN
  assign sync_done = frame_start;
`else
  logic unused_frame_start;
  assign unused_frame_start = frame_start;
  assign sync_done = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_RUN;
      active_ch   <= '0;
      custom      <= 1'b1;
      camera_rstn <= 1'b1;
      req_err     <= 1'b0;
      pend_valid  <= 1'b0;
      pend_ch     <= '0;
      pend_custom <= 1'b0;
      cnt         <= 8'd0;
    end else begin
      state       <= state_nxt;
      active_ch   <= active_ch_nxt;
      custom      <= custom_nxt;
      camera_rstn <= camera_rstn_nxt;
      req_err     <= req_err_nxt;
      pend_valid  <= pend_valid_nxt;
      pend_ch     <= pend_ch_nxt;
      pend_custom <= pend_custom_nxt;
      cnt         <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    active_ch_nxt   = active_ch;
    custom_nxt      = custom;
    camera_rstn_nxt = camera_rstn;
    req_err_nxt     = req_valid && !req_legal;
    pend_valid_nxt  = pend_valid;
    pend_ch_nxt     = pend_ch;
    pend_custom_nxt = pend_custom;
    cnt_nxt         = cnt;

    if (state != S_RUN && fresh) begin
      pend_valid_nxt  = 1'b1;
      pend_ch_nxt     = req_ch;
      pend_custom_nxt = req_custom;
    end

    case (state)
      S_RUN: begin
        pend_valid_nxt = 1'b0;
        if (eval_valid && !(eval_ch == active_ch && eval_custom == custom)) begin
          active_ch_nxt   = eval_ch;
          custom_nxt      = eval_custom;
          camera_rstn_nxt = 1'b0;
          cnt_nxt         = 8'd0;
          state_nxt       = S_RST_PULSE;
        end
      end
      S_RST_PULSE: begin
        if (cnt == CNT_LAST) begin
          camera_rstn_nxt = 1'b1;
          state_nxt       = S_SYNC;
        end else if (cnt != 8'hFF) begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      S_SYNC: begin
        if (sync_done) state_nxt = S_RUN;
      end
      default: state_nxt = S_RUN;
    endcase
  end

  assign sdram_wrdata   = src_data[int'(active_ch)*DATA_W +: DATA_W];
  assign sdram_max_addr = MAX_ADDR_LIST[int'(active_ch)*ADDR_W +: ADDR_W];
  assign sdram_wren     = (state == S_RUN) && src_en[active_ch];
  assign busy           = (state != S_RUN);

endmodule

// File: tb/tb_video_src_switch.sv
// Scoreboard bench for video_src_switch with three channels: stimulus pushes expected SDRAM writes, a negedge monitor checks them.
// Handles both the default build and VIDEO_SRC_FRAME_SYNC_EN.
module tb_video_src_switch;
  localparam int NUM_CH = 3;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 23;
  localparam int RST_LEN = 4;
  localparam int CH_W = 2;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] addr;
    logic [CH_W-1:0]   ch;
    logic              cu;
  } wr_t;

  logic clk = 0, rst = 1;
  logic req_valid = 0, req_custom = 0, frame_start = 0;
  logic [CH_W-1:0] req_ch = '0;
  logic [NUM_CH-1:0] src_en = '0;
  logic [NUM_CH*DATA_W-1:0] src_data = '0;
  logic [DATA_W-1:0] sdram_wrdata;
  logic sdram_wren, camera_rstn, custom, busy, req_err;
  logic [ADDR_W-1:0] sdram_max_addr;
  logic [CH_W-1:0] active_ch;

  wr_t exp_q[$];
  int tests = 0, fails = 0;

  video_src_switch #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .RST_LEN(RST_LEN),
    .MAX_ADDR_LIST({23'd100, 23'd655360, 23'd53248})
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ch(req_ch), .req_custom(req_custom),
    .frame_start(frame_start), .src_en(src_en), .src_data(src_data),
    .sdram_wrdata(sdram_wrdata), .sdram_wren(sdram_wren), .sdram_max_addr(sdram_max_addr),
    .camera_rstn(camera_rstn), .custom(custom), .active_ch(active_ch), .busy(busy), .req_err(req_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [ADDR_W-1:0] addr_of(input logic [CH_W-1:0] ch);
    case (ch)
      2'd0: addr_of = 23'd53248;
      2'd1: addr_of = 23'd655360;
      default: addr_of = 23'd100;
    endcase
  endfunction

  always @(negedge clk) begin
    if (!rst && sdram_wren) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", {8'd0, sdram_wrdata, 7'd0, sdram_wren}, 32'd0);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_data", 32'(sdram_wrdata), 32'(e.data));
        check("wr_addr", 32'(sdram_max_addr), 32'(e.addr));
        check("wr_ch", 32'(active_ch), 32'(e.ch));
        check("wr_custom", 32'(custom), 32'(e.cu));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [CH_W-1:0] ch, input logic cu);
    req_valid = 1; req_ch = ch; req_custom = cu;
    tick();
    req_valid = 0;
  endtask

  // One write cycle in RUN: every channel presents distinct data, only the active one may reach SDRAM.
  task automatic write_cycle(input logic [DATA_W-1:0] d0, input logic [DATA_W-1:0] d1,
                             input logic [DATA_W-1:0] d2, input logic [CH_W-1:0] ch, input logic cu);
    wr_t e;
    src_data = {d2, d1, d0};
    src_en = '1;
    e.data = (ch == 2'd0) ? d0 : (ch == 2'd1) ? d1 : d2;
    e.addr = addr_of(ch);
    e.ch = ch;
    e.cu = cu;
    exp_q.push_back(e);
    tick();
    src_en = '0;
  endtask

  task automatic finish_sync();
`ifdef VIDEO_SRC_FRAME_SYNC_EN
    frame_start = 1;
    tick();
    frame_start = 0;
`else
    tick();
`endif
  endtask

  initial begin
    #12;
    check("rst_rstn", 32'(camera_rstn), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ch", 32'(active_ch), 32'd0);
    check("rst_custom", 32'(custom), 32'd1);
    check("rst_err", 32'(req_err), 32'd0);
    check("rst_addr", 32'(sdram_max_addr), 32'd53248);
    tick();
    rst = 0;

    write_cycle(16'hABCD, 16'h1111, 16'h2222, 2'd0, 1'b1);
    write_cycle(16'h0F0F, 16'h3333, 16'h4444, 2'd0, 1'b1);

    // Same mode: ignored.
    req(2'd0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      check("same_mode_rstn", 32'(camera_rstn), 32'd1);
      check("same_mode_busy", 32'(busy), 32'd0);
      tick();
    end

    // Switch to ch1/custom 0; writes must be blocked while busy.
    req(2'd1, 1'b0);
    src_data = {16'h2222, 16'h1111, 16'h5A5A};
    src_en = '1;
    for (int i = 0; i < RST_LEN; i++) begin
      check("pulse_rstn", 32'(camera_rstn), 32'd0);
      check("pulse_busy", 32'(busy), 32'd1);
      tick();
    end
    check("sync_rstn", 32'(camera_rstn), 32'd1);
    check("sync_busy", 32'(busy), 32'd1);
`ifdef VIDEO_SRC_FRAME_SYNC_EN
    for (int i = 0; i < 100; i++) begin
      tick();
      check("wait_frame_busy", 32'(busy), 32'd1);
    end
`endif
    finish_sync();
    check("sw1_busy", 32'(busy), 32'd0);
    check("sw1_ch", 32'(active_ch), 32'd1);
    check("sw1_custom", 32'(custom), 32'd0);
    check("sw1_addr", 32'(sdram_max_addr), 32'd655360);
    write_cycle(16'h5A5A, 16'h1234, 16'h2222, 2'd1, 1'b0);
    tick();

    // Pending overwrite: ch0 then ch1 during the pulse, only ch1 survives.
    req(2'd2, 1'b1);
    check("p_rstn0", 32'(camera_rstn), 32'd0);
    req(2'd0, 1'b0);
    req(2'd1, 1'b1);
    tick();
    tick();
    check("p_sync_rstn", 32'(camera_rstn), 32'd1);
    finish_sync();
    check("p_run_busy", 32'(busy), 32'd0);
    check("p_run_ch", 32'(active_ch), 32'd2);
    write_cycle(16'h0001, 16'h0002, 16'hC0DE, 2'd2, 1'b1);
    check("p2_rstn", 32'(camera_rstn), 32'd0);
    check("p2_busy", 32'(busy), 32'd1);
    for (int i = 0; i < RST_LEN; i++) tick();
    finish_sync();
    check("p2_ch", 32'(active_ch), 32'd1);
    check("p2_custom", 32'(custom), 32'd1);
    check("p2_addr", 32'(sdram_max_addr), 32'd655360);
    for (int i = 0; i < 3; i++) begin
      check("p2_idle_busy", 32'(busy), 32'd0);
      tick();
    end

    // Fresh request on the first RUN cycle beats the pending one.
    req(2'd2, 1'b0);
    req(2'd0, 1'b0);
    tick(); tick(); tick();
    finish_sync();
    req(2'd1, 1'b0);
    check("fr_ch", 32'(active_ch), 32'd1);
    check("fr_rstn", 32'(camera_rstn), 32'd0);
    for (int i = 0; i < RST_LEN; i++) tick();
    finish_sync();
    for (int i = 0; i < 3; i++) begin
      check("fr_idle_busy", 32'(busy), 32'd0);
      check("fr_idle_ch", 32'(active_ch), 32'd1);
      tick();
    end

    // Illegal channel.
    req(2'd3, 1'b1);
    check("err_pulse", 32'(req_err), 32'd1);
    check("err_busy", 32'(busy), 32'd0);
    check("err_ch", 32'(active_ch), 32'd1);
    check("err_custom", 32'(custom), 32'd0);
    tick();
    check("err_clear", 32'(req_err), 32'd0);

    // Asynchronous reset in the middle of a pulse.
    req(2'd0, 1'b1);
    tick();
    check("mid_rstn_low", 32'(camera_rstn), 32'd0);
    rst = 1;
    #1;
    check("mid_rst_rstn", 32'(camera_rstn), 32'd1);
    check("mid_rst_ch", 32'(active_ch), 32'd0);
    check("mid_rst_custom", 32'(custom), 32'd1);
    check("mid_rst_busy", 32'(busy), 32'd0);
    rst = 0;
    tick();
    write_cycle(16'hBEEF, 16'h1111, 16'h2222, 2'd0, 1'b1);
    tick();

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/video_src_switch.md
VIDEO_SRC_SWITCH -- requirements
Module: video_src_switch

Interface
REQ-001 Parameter NUM_CH, default 2, number of pixel-source channels, legal range 2..8.
REQ-002 Parameter DATA_W, default 16, pixel word width.
REQ-003 Parameter ADDR_W, default 23, SDRAM address width.
REQ-004 Parameter RST_LEN, default 4, sensor-reset pulse length in clk cycles, legal range 1..255.
REQ-005 Parameter MAX_ADDR_LIST, default {23'd655360, 23'd53248}, NUM_CH*ADDR_W packed, per-channel frame end address, channel 0 in LSBs.
REQ-006 clk  in  1  single clock; all logic rising-edge.
REQ-007 rst  in  1  asynchronous reset, active-high.
REQ-008 req_valid  in  1  one-cycle mode-switch request strobe.
REQ-009 req_ch  in  clog2(NUM_CH)  requested channel index.
REQ-010 req_custom  in  1  requested sensor custom-config bit.
REQ-011 frame_start  in  1  one-cycle start-of-frame strobe from the active source.
REQ-012 src_en  in  NUM_CH  per-channel pixel valid.
REQ-013 src_data  in  NUM_CH*DATA_W  per-channel pixel data, channel 0 in LSBs.
REQ-014 sdram_wrdata  out  DATA_W  selected pixel data.
REQ-015 sdram_wren  out  1  selected pixel valid, gated by state.
REQ-016 sdram_max_addr  out  ADDR_W  end address of the active channel.
REQ-017 camera_rstn  out  1  sensor reset, active-low.
REQ-018 custom  out  1  sensor custom-config select.
REQ-019 active_ch  out  clog2(NUM_CH)  currently selected channel.
REQ-020 busy  out  1  high in any state other than RUN.
REQ-021 req_err  out  1  one-cycle pulse on a rejected request (req_ch >= NUM_CH).

Function
REQ-022 The FSM SHALL have states RUN, RST_PULSE, and SYNC.
REQ-023 In RUN, a request with req_ch == active_ch and req_custom == custom SHALL be ignored, with no pulse and no state change.
REQ-024 In RUN, any other legal request SHALL, on the next clk edge, load active_ch <= req_ch and custom <= req_custom, drive camera_rstn low, and enter RST_PULSE.
REQ-025 RST_PULSE SHALL hold camera_rstn low for exactly RST_LEN cycles, then release it to high and enter SYNC.
REQ-026 SYNC behaviour SHALL be as defined in REQ-036/037.
REQ-027 Requests arriving while busy SHALL be stored in a one-deep pending register; a newer request overwrites an older one.
REQ-028 On return to RUN, a valid pending request SHALL be evaluated on the first RUN cycle exactly as a fresh request (REQ-023/024) and then cleared.
REQ-029 A fresh req_valid in the same cycle as the pending evaluation SHALL take priority, and the pending request SHALL be discarded.
REQ-030 A request with req_ch >= NUM_CH SHALL be dropped in any state and SHALL pulse req_err for one cycle, with no other effect.
REQ-031 sdram_wrdata SHALL equal src_data[active_ch] combinationally (zero latency), in every state.
REQ-032 sdram_wren SHALL equal src_en[active_ch] in RUN and SHALL be 0 in RST_PULSE and SYNC.
REQ-033 sdram_max_addr SHALL equal MAX_ADDR_LIST[active_ch] combinationally.
REQ-034 The pulse counter SHALL be 8 bits, load 0 on entry to RST_PULSE, and never wrap.

Reset
REQ-035 On rst assertion, the block SHALL immediately and asynchronously apply: state = RUN, active_ch = 0, custom = 1, camera_rstn = 1, req_err = 0, pending cleared, counter = 0. Consequently busy = 0, sdram_wren = src_en[0], and sdram_max_addr = MAX_ADDR_LIST[0]. A reset mid-pulse SHALL abort the pulse and release camera_rstn at once.

Configuration
REQ-036 With macro VIDEO_SRC_FRAME_SYNC_EN defined, SYNC SHALL wait for frame_start and enter RUN on the edge after it, so the first write is frame-aligned; a frame_start during RST_PULSE SHALL be ignored.
REQ-037 Without VIDEO_SRC_FRAME_SYNC_EN, SYNC SHALL last exactly one cycle, frame_start SHALL be unused, and the request-to-RUN latency SHALL be RST_LEN+2 cycles.

Verification
REQ-038 Reset, then src_en[0]=1, src_data[0]=16'hABCD -> sdram_wrdata=16'hABCD, sdram_wren=1, sdram_max_addr=53248, custom=1, camera_rstn=1.
REQ-039 RUN, request ch1 with custom=0, RST_LEN=4, macro off -> camera_rstn low for exactly 4 cycles, wren 0 throughout, busy high for 5 cycles, then active_ch=1, sdram_max_addr=655360, custom=0.
REQ-040 Request ch0 with custom=1 while already in that mode -> no camera_rstn pulse, busy stays 0.
REQ-041 During RST_PULSE, request ch0 then ch1 -> only ch1 is kept pending; after return to RUN, a second pulse starts on the first RUN cycle (or no pulse if ch1/custom already match).
REQ-042 Macro on, frame_start held low for 100 cycles after the pulse -> busy stays high and wren stays 0; frame_start pulse -> RUN on the next cycle, wren follows src_en.
REQ-043 NUM_CH=3, request req_ch=3 -> req_err single-cycle pulse, no state change; rst asserted mid-pulse -> camera_rstn=1 and active_ch=0 immediately.
